bin_to_bcd_seq: RTL and testbench

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/bin_to_bcd_seq.sv | 89 ++++++++
 tb/tb_bin_to_bcd_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock,
// with valid/ready handshakes on both the operand and result sides.
module bin_to_bcd_seq #(
  parameter int N = 24,
  parameter int D = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           In_Valid,
  input  logic [N-1:0]   Bin_In,
  output logic           In_Ready,
  output logic           Out_Valid,
  input  logic           Out_Ready,
  output logic [4*D-1:0] BCD_Out,
  output logic           Busy
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   sreg;
  logic [4*D-1:0] acc, adj, acc_nxt;
  logic [CW-1:0]  cnt;
  logic [4*D-1:0] bcd_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (In_Valid)        state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST)     state_nxt = DONE;
      DONE:    if (Out_Ready)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_comb begin
    In_Ready  = (state == IDLE);
    Busy      = (state == SHIFT);
    Out_Valid = (state == DONE);
  end

  // Add-3 correction on every digit, then shift the next operand bit into digit 0
  always_comb begin
    adj = acc;
    for (int unsigned i = 0; i < D; i++) begin
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    acc_nxt = {adj[4*D-2:0], sreg[N-1]};
  end

  // Result is captured into its own register so BCD_Out holds the last answer
  // while the accumulator is reused by the next conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg  <= '0;
      acc   <= '0;
      cnt   <= '0;
      bcd_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (In_Valid) begin
            sreg <= Bin_In;
            acc  <= '0;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          acc  <= acc_nxt;
          sreg <= sreg << 1;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) bcd_q <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

  assign BCD_Out = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed, table-driven bench for bin_to_bcd_seq (N=24, D=8).
module tb_bin_to_bcd_seq;

  localparam int N = 24;
  localparam int D = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           In_Valid;
  logic [N-1:0]   Bin_In;
  logic           In_Ready;
  logic           Out_Valid;
  logic           Out_Ready;
  logic [4*D-1:0] BCD_Out;
  logic           Busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [N-1:0]   bin;
    logic [4*D-1:0] bcd;
  } vec_t;

  vec_t tbl[11];

  bin_to_bcd_seq #(.N(N), .D(D)) dut (
    .clk(clk), .rst(rst), .In_Valid(In_Valid), .Bin_In(Bin_In),
    .In_Ready(In_Ready), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .BCD_Out(BCD_Out), .Busy(Busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One full transaction: accept, count latency and Busy, check result, release.
  task automatic run_op(input logic [N-1:0] b, input logic [4*D-1:0] e);
    int t;
    int busy_n;
    t = 0;
    @(negedge clk);
    while (!In_Ready && t < 100) begin @(negedge clk); t++; end
    chk("in_ready_before_accept", In_Ready, 1);
    In_Valid = 1'b1;
    Bin_In   = b;
    @(posedge clk);
    @(negedge clk);
    In_Valid = 1'b0;
    t = 0;
    busy_n = 0;
    while (!Out_Valid && t < 100) begin
      if (Busy) busy_n++;
      @(negedge clk);
      t++;
    end
    chk("latency", t, N);
    chk("busy_cycles", busy_n, N);
    chk("bcd_out", BCD_Out, e);
    chk("busy_in_done", Busy, 0);
    Out_Ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Out_Ready = 1'b0;
    chk("idle_after_release", In_Ready, 1);
    chk("out_valid_dropped", Out_Valid, 0);
    chk("bcd_retained", BCD_Out, e);
  endtask

  initial begin
    int t;
    int prev_acc;
    tbl[0]  = '{24'h000000, 32'h00000000};
    tbl[1]  = '{24'h12D687, 32'h01234567};
    tbl[2]  = '{24'hFFFFFF, 32'h16777215};
    tbl[3]  = '{24'h000001, 32'h00000001};
    tbl[4]  = '{24'h000009, 32'h00000009};
    tbl[5]  = '{24'h00000A, 32'h00000010};
    tbl[6]  = '{24'h000063, 32'h00000099};
    tbl[7]  = '{24'h000064, 32'h00000100};
    tbl[8]  = '{24'h0F423F, 32'h00999999};
    tbl[9]  = '{24'hBC614E, 32'h12345678};
    tbl[10] = '{24'h000005, 32'h00000005};

    rst = 1'b1; In_Valid = 1'b0; Bin_In = '0; Out_Ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", In_Ready, 1);
    chk("rst_out_valid", Out_Valid, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_bcd", BCD_Out, 0);
    rst = 1'b0;

    foreach (tbl[i]) run_op(tbl[i].bin, tbl[i].bcd);

    // Backpressure: result held for 10 cycles, In_Valid pulses ignored
    @(negedge clk);
    In_Valid = 1'b1; Bin_In = 24'h12D687;
    @(posedge clk);
    @(negedge clk);
    In_Valid = 1'b0;
    t = 0;
    while (!Out_Valid && t < 100) begin @(negedge clk); t++; end
    chk("bp_latency", t, N);
    for (int k = 0; k < 10; k++) begin
      In_Valid = k[0];
      Bin_In   = 24'h000007;
      @(posedge clk);
      @(negedge clk);
      chk("bp_out_valid_held", Out_Valid, 1);
      chk("bp_bcd_held", BCD_Out, 32'h01234567);
      chk("bp_in_ready_low", In_Ready, 0);
    end
    In_Valid = 1'b0; Out_Ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Out_Ready = 1'b0;
    chk("bp_release_idle", In_Ready, 1);
    chk("bp_release_ov", Out_Valid, 0);

    // Reset on shift cycle 12 discards the operation
    In_Valid = 1'b1; Bin_In = 24'h000064;
    @(posedge clk);
    @(negedge clk);
    In_Valid = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", Busy, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", In_Ready, 1);
    chk("midrst_out_valid", Out_Valid, 0);
    chk("midrst_busy", Busy, 0);
    chk("midrst_bcd", BCD_Out, 0);
    t = 0;
    repeat (30) begin @(negedge clk); if (Out_Valid) t++; end
    chk("midrst_no_pulse", t, 0);
    run_op(24'h000064, 32'h00000100);

    // Back-to-back with In_Valid held and Out_Ready=1: accepts every N+2 cycles
    Out_Ready = 1'b1;
    In_Valid  = 1'b1;
    prev_acc  = 0;
    for (int k = 0; k < 4; k++) begin
      t = 0;
      while (!In_Ready && t < 100) begin @(negedge clk); t++; end
      chk("b2b_ready", In_Ready, 1);
      Bin_In = tbl[k + 1].bin;
      if (k > 0) chk("b2b_spacing", cyc - prev_acc, N + 2);
      prev_acc = cyc;
      @(negedge clk);
      t = 0;
      while (!Out_Valid && t < 100) begin @(negedge clk); t++; end
      chk("b2b_bcd", BCD_Out, tbl[k + 1].bcd);
      if (k == 3) In_Valid = 1'b0;
      @(negedge clk);
    end
    Out_Ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_final_idle", In_Ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
